// File: rtl/apb_initiator_pkg.sv
// Shared types and constants for the APB initiator and its watchdog.
package apb_initiator_pkg;

  // Byte address and data word carried on the APB bus.
  typedef logic [31:0] apbAddrSt;
  typedef logic [31:0] apbDataSt;

  // Transfer sequencing: idle, APB SETUP phase, APB ACCESS phase, response held.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apbInitStateT;

  // Request as captured at acceptance.
  typedef struct packed {
    logic     write;
    apbAddrSt addr;
    apbDataSt wdata;
  } apbInitReqSt;

  // Response as presented on the response channel.
  typedef struct packed {
    apbDataSt rdata;
    logic     err;
  } apbInitRspSt;

  // Read data returned when a transfer is abandoned by the watchdog.
  localparam apbDataSt APB_INIT_TIMEOUT_DATA = 32'hDEAD_DEAD;

  // Only word-aligned addresses are put on the bus.
  function automatic logic apb_init_aligned(input apbAddrSt addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/apb_if.sv
// APB bus bundle between the initiator (src) and the register responders (dst).
interface apb_if;
  import apb_initiator_pkg::*;

  apbAddrSt paddr;
  apbDataSt pwdata;
  logic     pwrite;
  logic     psel;
  logic     penable;
  apbDataSt prdata;
  logic     pready;
  logic     pslverr;

  modport src (
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata, pready, pslverr
  );

  modport dst (
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_initiator_wdog.sv
// ACCESS-phase watchdog: counts ACCESS cycles without pready and flags expiry
// on the cycle where the count reaches TIMEOUT-1 with pready still low.
// Only instantiated when APB_INITIATOR_TIMEOUT_EN is defined.
module apb_initiator_wdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic start_i,   // high in SETUP: counter clears on entry to ACCESS
  input  logic active_i,  // high in ACCESS
  input  logic pready_i,
  output logic expired_o
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: clear before ACCESS, advance on every stalled ACCESS cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = 8'd0;
    end else if (active_i && !pready_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // pready in the same cycle takes precedence, so expiry requires it low.
  assign expired_o = active_i && !pready_i && (cnt_q == LAST);

endmodule

// File: rtl/apb_initiator.sv
// APB initiator: turns one valid/ready register request into one APB transfer
// (SETUP then ACCESS) and returns read data / error on a valid/ready response.
// Misaligned requests are answered with an error without touching the bus.
// Optional ACCESS timeout: define APB_INITIATOR_TIMEOUT_EN.
//
// Handshakes: a request transfers on a cycle where req_valid && req_ready;
// a response transfers on a cycle where rsp_valid && rsp_ready. rsp_valid,
// rsp_rdata and rsp_err stay stable from assertion until that transfer.
module apb_initiator
  import apb_initiator_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  apb_if.src           apbReg,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [31:0]  req_addr,
  input  logic [31:0]  req_wdata,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [31:0]  rsp_rdata,
  output logic         rsp_err,
  output apbInitStateT dbg_state_o
);

  apbInitStateT state_q, state_d;
  apbInitReqSt  req_q, req_d;
  apbInitRspSt  rsp_q, rsp_d;
  logic         live_q;   // low only in the first cycle after reset, keeps req_ready at 0 in reset
  logic         expired;

`ifdef APB_INITIATOR_TIMEOUT_EN
  apb_initiator_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .start_i   (state_q == SETUP),
    .active_i  (state_q == ACCESS),
    .pready_i  (apbReg.pready),
    .expired_o (expired)
  );
`else
  // Without the watchdog ACCESS waits for pready indefinitely; TIMEOUT has no effect.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign expired        = 1'b0;
`endif

  // Next-state, capture and response logic.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    rsp_d     = rsp_q;
    req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = live_q;
        if (req_valid && live_q) begin
          req_d.write = req_write;
          req_d.addr  = req_addr;
          req_d.wdata = req_wdata;
          if (!apb_init_aligned(req_addr)) begin
            rsp_d.rdata = '0;
            rsp_d.err   = 1'b1;
            state_d     = RESP;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (apbReg.pready) begin
          rsp_d.rdata = req_q.write ? '0 : apbReg.prdata;
          rsp_d.err   = apbReg.pslverr;
          state_d     = RESP;
        end else if (expired) begin
          rsp_d.rdata = APB_INIT_TIMEOUT_DATA;
          rsp_d.err   = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, captured request and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      rsp_q   <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rsp_q   <= rsp_d;
      live_q  <= 1'b1;
    end
  end

  // Bus strobes decode from state so an asynchronous reset drops them at once.
  assign apbReg.psel    = (state_q == SETUP) || (state_q == ACCESS);
  assign apbReg.penable = (state_q == ACCESS);
  assign apbReg.paddr   = req_q.addr;
  assign apbReg.pwdata  = req_q.wdata;
  assign apbReg.pwrite  = req_q.write;

  assign rsp_valid   = (state_q == RESP);
  assign rsp_rdata   = rsp_q.rdata;
  assign rsp_err     = rsp_q.err;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_initiator.sv
// Bench for apb_initiator: register responder with configurable wait states,
// directed vector table, multi-cycle corner sequences and randomized traffic
// checked against a transaction-level model.
module tb_apb_initiator;
  import apb_initiator_pkg::*;

  localparam int TO = 4;
  localparam logic [31:0] UNMAPPED_DATA = 32'hBADD_C0DE;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  apb_if bus ();

  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_write = 1'b0;
  logic [31:0]  req_addr  = '0;
  logic [31:0]  req_wdata = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;
  apbInitStateT dbg_state;

  apb_initiator #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .apbReg      (bus),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .dbg_state_o (dbg_state)
  );

  // ---------------- responder ----------------
  // 16 word registers at 0x00..0x3C, except 0x04 which is unmapped (as is >= 0x40).
  logic [31:0] rmem [16] = '{default: 32'h0};
  int   ws_cfg      = 0;
  logic hang        = 1'b0;
  logic late_pready = 1'b0;   // pready driven outside ACCESS, must be ignored
  int   wcnt        = 0;

  function automatic logic mapped(input logic [31:0] a);
    return (a < 32'h40) && (a != 32'h4);
  endfunction

  always_comb begin
    bus.pready  = late_pready;
    bus.pslverr = 1'b0;
    bus.prdata  = 32'h0;
    if (bus.psel && bus.penable) begin
      bus.pready  = !hang && (wcnt >= ws_cfg);
      bus.pslverr = bus.pready && !mapped(bus.paddr);
      bus.prdata  = mapped(bus.paddr) ? rmem[bus.paddr[5:2]] : UNMAPPED_DATA;
    end
  end

  always @(posedge clk) begin
    if (bus.psel && bus.penable && !bus.pready) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (bus.psel && bus.penable && bus.pready && bus.pwrite && mapped(bus.paddr))
      rmem[bus.paddr[5:2]] <= bus.pwdata;
  end

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] mmem [16] = '{default: 32'h0};
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Transaction-level prediction: result, latency in cycles after acceptance,
  // and number of cycles psel is seen.
  task automatic model_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input int ws, output logic [31:0] er, output logic ee,
                           output int lat, output int pc);
    if (a[1:0] != 2'b00) begin
      er = 32'h0; ee = 1'b1; lat = 1; pc = 0;
    end else begin
      pc  = 2 + ws;
      lat = 3 + ws;
      ee  = !mapped(a);
      er  = w ? 32'h0 : (mapped(a) ? mmem[a[5:2]] : UNMAPPED_DATA);
      if (w && mapped(a)) mmem[a[5:2]] = d;
    end
  endtask

  // ---------------- driver ----------------
  // Called and returns at a negedge.
  task automatic do_txn(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input int ws, input int bp,
                        input logic [31:0] er, input logic ee, input int lat, input int pc);
    int cyc; int pcyc; int guard; logic bus_ok; logic hold_ok;
    logic [31:0] rd0; logic er0;
    ws_cfg = ws; req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    if (!req_ready) begin
      chk({tag, " accept"}, 32'(req_ready), 32'h1);
      req_valid = 1'b0;
      return;
    end
    cyc = 0; pcyc = 0; bus_ok = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      req_valid = 1'b0;
      if (bus.psel) begin
        pcyc++;
        if (bus.paddr !== a || bus.pwrite !== w || bus.pwdata !== d) bus_ok = 1'b0;
        if (bus.penable !== (pcyc > 1)) bus_ok = 1'b0;
      end
    end while (!rsp_valid && cyc < 100);
    chk({tag, " latency"}, 32'(cyc), 32'(lat));
    chk({tag, " psel_cycles"}, 32'(pcyc), 32'(pc));
    chk({tag, " bus_fields"}, 32'(bus_ok), 32'h1);
    exp_q.push_back(er);
    chk({tag, " rdata"}, rsp_rdata, exp_q.pop_front());
    chk({tag, " err"}, 32'(rsp_err), 32'(ee));
    rd0 = rsp_rdata; er0 = rsp_err; hold_ok = 1'b1;
    for (int i = 0; i < bp; i++) begin
      if (!rsp_valid || rsp_rdata !== rd0 || rsp_err !== er0 || req_ready ||
          bus.psel || bus.penable) hold_ok = 1'b0;
      @(negedge clk);
    end
    if (bp > 0) chk({tag, " backpressure_hold"}, 32'(hold_ok), 32'h1);
    rsp_ready = 1'b1;
    chk({tag, " req_ready_in_resp"}, 32'(req_ready), 32'h0);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, " rsp_valid_after"}, 32'(rsp_valid), 32'h0);
    chk({tag, " req_ready_after"}, 32'(req_ready), 32'h1);
  endtask

  // Start an aligned read and return at the first negedge with penable high.
  task automatic start_to_access(input logic [31:0] a, output logic ok);
    int guard;
    req_write = 1'b0; req_addr = a; req_wdata = 32'h1234; req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (!bus.penable && guard < 10) begin @(negedge clk); guard++; end
    ok = bus.penable;
  endtask

  // Assert reset mid-cycle during ACCESS and check the bus drops immediately.
  task automatic mid_access_reset(input string tag);
    int guard;
    #2 rst_n = 1'b0;
    #1;
    chk({tag, " psel"}, 32'(bus.psel), 32'h0);
    chk({tag, " penable"}, 32'(bus.penable), 32'h0);
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    hang = 1'b0;
    guard = 0;
    while (!req_ready && guard < 10) begin @(negedge clk); guard++; end
    chk({tag, " ready_again"}, 32'(req_ready), 32'h1);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    string       tag;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    int          ws;
    int          bp;
    logic [31:0] er;
    logic        ee;
    int          lat;
    int          pc;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [31:0] er; logic ee; int lat; int pc; logic ok; int guard;

    tbl[0] = '{"wr0_zero_wait",  1'b1, 32'h0,  32'h5A,       0, 0, 32'h0,         1'b0, 3, 2};
    tbl[1] = '{"wr8",            1'b1, 32'h8,  32'h7,        0, 0, 32'h0,         1'b0, 3, 2};
    tbl[2] = '{"rd8_one_wait",   1'b0, 32'h8,  32'hFFFF,     1, 0, 32'h7,         1'b0, 4, 3};
    tbl[3] = '{"rd4_unmapped",   1'b0, 32'h4,  32'h0,        0, 0, UNMAPPED_DATA, 1'b1, 3, 2};
    tbl[4] = '{"rd2_misaligned", 1'b0, 32'h2,  32'h0,        0, 0, 32'h0,         1'b1, 1, 0};
    tbl[5] = '{"rd0_readback",   1'b0, 32'h0,  32'h0,        0, 5, 32'h5A,        1'b0, 3, 2};
    tbl[6] = '{"wr13_misalign",  1'b1, 32'h13, 32'hAAAA,     0, 0, 32'h0,         1'b1, 1, 0};
    tbl[7] = '{"wr4_unmapped",   1'b1, 32'h4,  32'h1111,     2, 1, 32'h0,         1'b1, 5, 4};
    tbl[8] = '{"rd0_back2back",  1'b0, 32'h0,  32'h0,        0, 0, 32'h5A,        1'b0, 3, 2};

    // Reset values.
    #2 rst_n = 1'b0;
    #1;
    chk("reset psel", 32'(bus.psel), 32'h0);
    chk("reset penable", 32'(bus.penable), 32'h0);
    chk("reset paddr", bus.paddr, 32'h0);
    chk("reset pwdata", bus.pwdata, 32'h0);
    chk("reset pwrite", 32'(bus.pwrite), 32'h0);
    chk("reset req_ready", 32'(req_ready), 32'h0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    chk("reset rsp_err", 32'(rsp_err), 32'h0);
    chk("reset state", 32'(dbg_state), 32'(IDLE));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      model_txn(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].ws, er, ee, lat, pc);
      do_txn(tbl[i].tag, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].ws, tbl[i].bp,
             tbl[i].er, tbl[i].ee, tbl[i].lat, tbl[i].pc);
    end

    // Reset during ACCESS drops the bus at once.
    start_to_access(32'h10, ok);
    chk("rst_access reached", 32'(ok), 32'h1);
    if (ok) mid_access_reset("rst_access");

`ifdef APB_INITIATOR_TIMEOUT_EN
    // Responder never readies; stray pready outside ACCESS must be ignored.
    hang = 1'b1; late_pready = 1'b1;
    do_txn("timeout", 1'b0, 32'h0, 32'h0, 0, 3, APB_INIT_TIMEOUT_DATA, 1'b1, TO + 2, TO + 1);
    hang = 1'b0; late_pready = 1'b0;
`else
    // Without the watchdog the transfer waits indefinitely.
    hang = 1'b1;
    start_to_access(32'h0, ok);
    guard = 0;
    repeat (40) begin
      if (!(bus.psel && bus.penable && !rsp_valid)) ok = 1'b0;
      @(negedge clk);
    end
    chk("no_timeout psel_held", 32'(ok), 32'h1);
    mid_access_reset("no_timeout rst");
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 40; n++) begin
      logic w; logic [31:0] a; logic [31:0] d; int ws; int bp; int r;
      w = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      if (r == 0)      a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
      else if (r == 1) a = 32'h4;
      else if (r == 2) a = 32'h40 + (32'($urandom_range(0, 15)) << 2);
      else             a = 32'($urandom_range(0, 15)) << 2;
      d  = $urandom;
      ws = int'($urandom_range(0, 3));
      bp = int'($urandom_range(0, 3));
      late_pready = 1'($urandom_range(0, 1));
      model_txn(w, a, d, ws, er, ee, lat, pc);
      do_txn($sformatf("rand%0d", n), w, a, d, ws, bp, er, ee, lat, pc);
    end
    late_pready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_initiator.md
Name: apb_initiator

Overview:
- APB requester that turns a simple valid/ready register-access request into one APB transfer (SETUP, then ACCESS) and returns read data and error status on a valid/ready response channel.
- Sits between a control source (CPU bridge, test sequencer, config loader) and the register-block APB responders.
- Exactly one transfer is outstanding at a time.

Parameters:
- TIMEOUT, 16, maximum ACCESS cycles without pready before the transfer is aborted (used only when the optional feature is compiled in); legal range 2..255.

Ports:
- clk  input  1  single clock.
- rst_n  input  1  reset, asynchronous, active-low.
- apbReg  apb_if.src  -  APB bus toward responders: paddr, pwdata, pwrite, psel, penable out; prdata, pready, pslverr in.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when high together with req_valid.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  32  byte address (apbAddrSt).
- req_wdata  input  32  write data (apbDataSt).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumed when high together with rsp_valid.
- rsp_rdata  output  32  read data; 0 for writes.
- rsp_err  output  1  pslverr, misalignment or timeout.

Behaviour:
- Reset values: all outputs 0, including psel, penable, paddr, pwdata, pwrite, req_ready, rsp_valid, rsp_rdata and rsp_err. State is IDLE.
- Reset taking effect mid-transfer drops psel and penable immediately; any pending response is lost.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready = 1, combinational from state.
  - On req_valid & req_ready, capture write, addr and wdata.
  - If addr[1:0] != 0: no APB transfer; go to RESP with err = 1, rdata = 0.
  - Otherwise go to SETUP.
- SETUP: psel = 1, penable = 0; always go to ACCESS after one cycle.
- ACCESS:
  - psel = 1, penable = 1.
  - paddr, pwrite and pwdata are registered and held stable from SETUP through the end of ACCESS.
  - On pready: rdata = prdata for reads, 0 for writes; err = pslverr; go to RESP.
  - psel and penable are 0 in the following cycle.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err held stable until rsp_ready.
  - On rsp_ready go to IDLE.
  - req_ready = 0 in RESP; a request can be accepted no earlier than the cycle after the response handshake.
- Latency with a zero-wait responder: accept at T0, SETUP at T1, ACCESS at T2 with pready, rsp_valid at T3. Each responder wait state adds one cycle.
- pwdata carries the captured value for reads as well; responders ignore it.
- pready or pslverr arriving outside ACCESS are ignored.
- Response backpressure (rsp_ready held low) never affects the bus: the bus is already idle in RESP.

Optional Feature:
- Macro: APB_INITIATOR_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to ACCESS and increments on each ACCESS cycle with pready = 0.
  - When the count reaches TIMEOUT - 1 with pready still 0: drop psel and penable in the next cycle and go to RESP with err = 1, rdata = 32'hDEAD_DEAD.
  - pready in that same cycle wins over the timeout: a normal completion.
- Undefined: no counter; ACCESS waits indefinitely for pready.

Decomposition:
- Shared package holds:
  - apbInitStateT enum (IDLE, SETUP, ACCESS, RESP).
  - apbInitReqSt (write, addr, wdata) and apbInitRspSt (rdata, err).
  - APB_INIT_TIMEOUT_DATA = 32'hDEAD_DEAD.
  - apbAddrSt and apbDataSt, reused from the existing package.
- One optional sub-module, apb_initiator_wdog: the timeout counter, instantiated only under the macro. FSM and datapath stay in apb_initiator.

Test Plan:
- Zero-wait write: addr 0x0, wdata 0x5A, to a register responder with APB_READY_1WS = 0 -> psel at T1, penable at T2, rsp_valid at T3 with err = 0, rdata = 0; responder register reads back 0x5A.
- One-wait read: addr 0x8 with APB_READY_1WS = 1, responder value 0x7 -> ACCESS lasts 2 cycles, rsp_rdata = 0x7, err = 0, paddr stable for all 3 bus cycles.
- Unmapped read: addr 0x4 -> pslverr = 1 -> rsp_err = 1, rsp_rdata = 0xBADDC0DE.
- Misaligned request: addr 0x2 -> no psel ever asserted, rsp_valid one cycle after acceptance, err = 1, rdata = 0.
- Backpressure and back-to-back:
  - rsp_ready held low 5 cycles -> rsp_valid and data stable, req_ready = 0, bus idle.
  - After the rsp_ready handshake, the next request is accepted one cycle later.
  - Reset asserted during ACCESS -> psel, penable and rsp_valid go to 0 immediately.
- Timeout (macro defined, TIMEOUT = 4), responder never raises pready -> psel drops after 4 ACCESS cycles, rsp_err = 1, rsp_rdata = 0xDEADDEAD. Late pready ignored. With the macro undefined, psel stays high.
